// File: rtl/obi_mem_arbiter_pkg.sv
// obi_mem_arbiter_pkg: host IDs, lock state type and sizing helper for the OBI arbiter
package obi_mem_arbiter_pkg;
    localparam logic OBI_HOST_FETCH = 1'b0;
    localparam logic OBI_HOST_DATA  = 1'b1;

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_e;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/obi_owner_fifo.sv
// obi_owner_fifo: register-based in-order FIFO of 1-bit response owners
module obi_owner_fifo
    import obi_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          data_i,
    input  logic          pop_i,
    output logic          head_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == LAST ? '0 : p + 1'b1;
    endfunction

    // storage, wrapping pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= nxt(wptr_q);
            end
            if (pop_i) rptr_q <= nxt(rptr_q);
            cnt_q <= (push_i && !pop_i) ? cnt_q + 1'b1 : (!push_i && pop_i) ? cnt_q - 1'b1 : cnt_q;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign cnt_o   = cnt_q;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: round-robin 2-host OBI arbiter with address-phase lock and in-order response routing
module obi_mem_arbiter
    import obi_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64,
    localparam int unsigned BW = DW / 8,
    localparam int unsigned CW = $clog2(MAX_OUTST + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          h0_req_i,
    output logic          h0_gnt_o,
    input  logic [AW-1:0] h0_addr_i,
    input  logic          h0_we_i,
    input  logic [BW-1:0] h0_be_i,
    input  logic [DW-1:0] h0_wdata_i,
    output logic          h0_rvalid_o,
    output logic [DW-1:0] h0_rdata_o,
    input  logic          h1_req_i,
    output logic          h1_gnt_o,
    input  logic [AW-1:0] h1_addr_i,
    input  logic          h1_we_i,
    input  logic [BW-1:0] h1_be_i,
    input  logic [DW-1:0] h1_wdata_i,
    output logic          h1_rvalid_o,
    output logic [DW-1:0] h1_rdata_o,
    output logic          dev_req_o,
    input  logic          dev_gnt_i,
    output logic [AW-1:0] dev_addr_o,
    output logic          dev_we_o,
    output logic [BW-1:0] dev_be_o,
    output logic [DW-1:0] dev_wdata_o,
    input  logic          dev_rvalid_i,
    input  logic [DW-1:0] dev_rdata_i,
    output logic [CW-1:0] outst_cnt_o,
    output logic          proto_err_o
);
    lock_state_e state_q, state_d;
    logic owner_q, owner_d, rr_last_q, rr_last_d, perr_q;
    logic sel, sel_req, hs, pop, head, full, empty;

    // a lock pins the selection so an ungranted address phase stays stable
    assign sel = state_q == ST_LOCKED ? owner_q
               : (h0_req_i && h1_req_i) ? ~rr_last_q
               : h1_req_i ? OBI_HOST_DATA : OBI_HOST_FETCH;
    assign sel_req     = sel ? h1_req_i : h0_req_i;
    assign dev_req_o   = !full && sel_req;
    assign hs          = dev_req_o && dev_gnt_i;
    assign dev_addr_o  = sel ? h1_addr_i : h0_addr_i;
    assign dev_we_o    = sel ? h1_we_i : h0_we_i;
    assign dev_be_o    = sel ? h1_be_i : h0_be_i;
    assign dev_wdata_o = sel ? h1_wdata_i : h0_wdata_i;
    assign h0_gnt_o    = hs && sel == OBI_HOST_FETCH;
    assign h1_gnt_o    = hs && sel == OBI_HOST_DATA;

    assign pop         = dev_rvalid_i && !empty;
    assign h0_rvalid_o = pop && head == OBI_HOST_FETCH;
    assign h1_rvalid_o = pop && head == OBI_HOST_DATA;
    assign h0_rdata_o  = dev_rdata_i;
    assign h1_rdata_o  = dev_rdata_i;
    assign proto_err_o = perr_q;

    // lock on a stalled request, release on handshake; round-robin pointer tracks the last winner
    always_comb begin
        state_d   = hs ? ST_UNLOCKED : dev_req_o ? ST_LOCKED : state_q;
        owner_d   = (dev_req_o && !hs) ? sel : owner_q;
        rr_last_d = hs ? sel : rr_last_q;
    end

    // arbitration state and sticky protocol-error flag for responses with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_UNLOCKED;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            perr_q    <= perr_q || (dev_rvalid_i && empty);
        end
    end

    obi_owner_fifo #(.DEPTH(MAX_OUTST)) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .cnt_o   (outst_cnt_o),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed-vector bench for the two-host OBI arbiter
module tb_obi_mem_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = $clog2(3);

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic h0_req_i, h0_gnt_o, h0_we_i, h0_rvalid_o;
    logic [AW-1:0] h0_addr_i;
    logic [BW-1:0] h0_be_i;
    logic [DW-1:0] h0_wdata_i, h0_rdata_o;
    logic h1_req_i, h1_gnt_o, h1_we_i, h1_rvalid_o;
    logic [AW-1:0] h1_addr_i;
    logic [BW-1:0] h1_be_i;
    logic [DW-1:0] h1_wdata_i, h1_rdata_o;
    logic dev_req_o, dev_gnt_i, dev_we_o, dev_rvalid_i, proto_err_o;
    logic [AW-1:0] dev_addr_o;
    logic [BW-1:0] dev_be_o;
    logic [DW-1:0] dev_wdata_o, dev_rdata_i;
    logic [CW-1:0] outst_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.MAX_OUTST(2), .AW(AW), .DW(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h0_req_i(h0_req_i), .h0_gnt_o(h0_gnt_o), .h0_addr_i(h0_addr_i), .h0_we_i(h0_we_i),
        .h0_be_i(h0_be_i), .h0_wdata_i(h0_wdata_i), .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o),
        .h1_req_i(h1_req_i), .h1_gnt_o(h1_gnt_o), .h1_addr_i(h1_addr_i), .h1_we_i(h1_we_i),
        .h1_be_i(h1_be_i), .h1_wdata_i(h1_wdata_i), .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o),
        .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
        .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o), .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
        .outst_cnt_o(outst_cnt_o), .proto_err_o(proto_err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        {h0_req_i, h0_we_i, h1_req_i, h1_we_i, dev_gnt_i, dev_rvalid_i} = '0;
        h0_addr_i = '0; h1_addr_i = '0; h0_be_i = '1; h1_be_i = '1;
        h0_wdata_i = 64'h0A0A; h1_wdata_i = 64'h1B1B; dev_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        do_reset;
        #1;
        check("rst_req", dev_req_o, 0);
        check("rst_cnt", outst_cnt_o, 0);
        check("rst_perr", proto_err_o, 0);
        check("rst_gnt", {h0_gnt_o, h1_gnt_o}, 0);

        // single host h1, immediate grant, response two cycles later
        h1_req_i = 1; h1_addr_i = 64'h1000; h1_wdata_i = 64'h77; dev_gnt_i = 1;
        #1;
        check("t1_req", dev_req_o, 1);
        check("t1_gnt", {h0_gnt_o, h1_gnt_o}, 2'b01);
        check("t1_addr", dev_addr_o, 64'h1000);
        check("t1_wdata", dev_wdata_o, 64'h77);
        step;
        h1_req_i = 0; dev_gnt_i = 0;
        #1;
        check("t1_cnt1", outst_cnt_o, 1);
        step;
        dev_rvalid_i = 1; dev_rdata_i = 64'hDEAD_BEEF;
        #1;
        check("t1_rv", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
        check("t1_rdata", h1_rdata_o, 64'hDEAD_BEEF);
        step;
        dev_rvalid_i = 0;
        #1;
        check("t1_cnt0", outst_cnt_o, 0);

        // contention from reset with a response every cycle after the first grant
        do_reset;
        h0_req_i = 1; h1_req_i = 1; h0_addr_i = 64'hA0; h1_addr_i = 64'hB0; dev_gnt_i = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin h0_req_i = 0; h1_req_i = 0; end
            dev_rvalid_i = k >= 1;
            dev_rdata_i = 64'(k);
            #1;
            if (k < 4) begin
                check($sformatf("t2_gnt%0d", k), {h0_gnt_o, h1_gnt_o}, k % 2 == 0 ? 2'b10 : 2'b01);
                check($sformatf("t2_addr%0d", k), dev_addr_o, k % 2 == 0 ? 64'hA0 : 64'hB0);
            end
            if (k >= 1)
                check($sformatf("t2_rv%0d", k), {h0_rvalid_o, h1_rvalid_o}, (k - 1) % 2 == 0 ? 2'b10 : 2'b01);
            if (k >= 1 && k < 4)
                check($sformatf("t2_cnt%0d", k), outst_cnt_o, 1);
            step;
        end
        dev_rvalid_i = 0; dev_gnt_i = 0;
        #1;
        check("t2_cnt_end", outst_cnt_o, 0);

        // lock hold while h1 contends, then full boundary
        do_reset;
        h0_req_i = 1; h0_addr_i = 64'h2000; h1_req_i = 1; h1_addr_i = 64'h3000;
        for (int k = 0; k < 4; k++) begin
            dev_gnt_i = k == 3;
            #1;
            check($sformatf("t3_addr%0d", k), dev_addr_o, 64'h2000);
            check($sformatf("t3_req%0d", k), dev_req_o, 1);
            check($sformatf("t3_gnt%0d", k), {h0_gnt_o, h1_gnt_o}, k == 3 ? 2'b10 : 2'b00);
            step;
        end
        h0_req_i = 0;
        #1;
        check("t3_h1_gnt", {h0_gnt_o, h1_gnt_o}, 2'b01);
        check("t3_h1_addr", dev_addr_o, 64'h3000);
        step;
        h0_req_i = 1;
        #1;
        check("t3_full_req", dev_req_o, 0);
        check("t3_full_gnt", {h0_gnt_o, h1_gnt_o}, 2'b00);
        check("t3_full_cnt", outst_cnt_o, 2);
        step;
        dev_rvalid_i = 1;
        #1;
        check("t3_n_req", dev_req_o, 0);
        check("t3_n_rv", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
        step;
        dev_rvalid_i = 0;
        #1;
        check("t3_n1_req", dev_req_o, 1);
        check("t3_n1_cnt", outst_cnt_o, 1);
        check("t3_n1_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
        step;
        h0_req_i = 0; h1_req_i = 0; dev_gnt_i = 0;
        #1;
        check("t3_cnt2", outst_cnt_o, 2);
        dev_rvalid_i = 1; dev_rdata_i = 64'h55;
        #1;
        check("t3_drain_h1", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
        check("t3_rdata_bcast", h0_rdata_o, 64'h55);
        step;
        check("t3_drain_h0", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
        check("t3_drain_cnt", outst_cnt_o, 1);
        step;
        dev_rvalid_i = 0;
        #1;
        check("t3_cnt0", outst_cnt_o, 0);

        // simultaneous push and pop at count 1
        do_reset;
        h0_req_i = 1; dev_gnt_i = 1;
        step;
        h0_req_i = 0; h1_req_i = 1; dev_rvalid_i = 1;
        #1;
        check("t4_rv_old", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
        check("t4_gnt_new", {h0_gnt_o, h1_gnt_o}, 2'b01);
        check("t4_cnt_pre", outst_cnt_o, 1);
        step;
        h1_req_i = 0; dev_gnt_i = 0;
        #1;
        check("t4_cnt_same", outst_cnt_o, 1);
        check("t4_rv_new", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
        step;
        dev_rvalid_i = 0;
        #1;
        check("t4_cnt0", outst_cnt_o, 0);

        // spurious rvalid, sticky error, asynchronous mid-cycle reset
        dev_rvalid_i = 1;
        #1;
        check("t5_rv", {h0_rvalid_o, h1_rvalid_o}, 2'b00);
        step;
        dev_rvalid_i = 0;
        check("t5_perr", proto_err_o, 1);
        check("t5_cnt", outst_cnt_o, 0);
        repeat (3) step;
        check("t5_perr_hold", proto_err_o, 1);
        rst_ni = 0;
        #1;
        check("t5_perr_clr", proto_err_o, 0);
        check("t5_cnt_clr", outst_cnt_o, 0);
        #10 rst_ni = 1;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
Two-host to one-device OBI arbiter. It shares a single unified memory port between the fetch-side host (host 0) and the memory-stage data host (host 1). Address phases are arbitrated round-robin, and an in-order owner FIFO routes each response phase back to the host that issued it. The block sits between the two host drivers and the external memory.

Parameters:
MAX_OUTST, 2, maximum outstanding granted-but-unanswered transactions (1..8)
AW, 64, address width
DW, 64, data width; byte-enable width is DW/8

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
h0_req_i  in  1  host 0 address-phase request
h0_gnt_o  out  1  host 0 grant
h0_addr_i  in  AW  host 0 address
h0_we_i  in  1  host 0 write enable
h0_be_i  in  DW/8  host 0 byte enables
h0_wdata_i  in  DW  host 0 write data
h0_rvalid_o  out  1  host 0 response valid
h0_rdata_o  out  DW  host 0 read data
h1_*  same set as h0_*  host 1 (data side)
dev_req_o  out  1  device request
dev_gnt_i  in  1  device grant
dev_addr_o  out  AW  device address
dev_we_o  out  1  device write enable
dev_be_o  out  DW/8  device byte enables
dev_wdata_o  out  DW  device write data
dev_rvalid_i  in  1  device response valid
dev_rdata_i  in  DW  device read data
outst_cnt_o  out  $clog2(MAX_OUTST+1)  current outstanding count
proto_err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous and active-low. All state resets as follows: lock_q=0, lock_owner_q=0, rr_last_q=1 (host 0 wins the first tie), FIFO empty, count 0, proto_err_o=0.
- Address-phase states:
  - UNLOCKED: the selection is combinational. If exactly one host requests, pick it. If both request, pick the host not equal to rr_last_q.
  - LOCKED: the selection is forced to lock_owner_q, regardless of the other request.
- Issue condition: can_issue = (count < MAX_OUTST). dev_req_o = can_issue & selected host's req. The address, we, be and wdata muxes follow the selection. When nothing is selected, drive selection = host 0 and dev_req_o = 0.
- Grants: hN_gnt_o = dev_gnt_i & dev_req_o & (sel == N). The same-cycle, zero-latency grant path is required.
- Lock transitions:
  - UNLOCKED to LOCKED when dev_req_o=1 and dev_gnt_i=0. This keeps OBI address-phase stability: the other host cannot steal the bus mid-request.
  - LOCKED to UNLOCKED on the handshake (dev_req_o & dev_gnt_i).
- On every handshake: push sel into the owner FIFO, set rr_last_q = sel, count+1.
- Full boundary:
  - When count == MAX_OUTST, dev_req_o=0 even if dev_rvalid_i frees a slot in the same cycle. There is no pass-through.
  - LOCKED is never entered while full, because a lock requires a request, and a request requires can_issue.
- Response phase:
  - The owner is the FIFO head. hN_rvalid_o = dev_rvalid_i & (count != 0) & (head == N).
  - Both h0_rdata_o and h1_rdata_o = dev_rdata_i, unconditionally.
  - On dev_rvalid_i with count != 0: pop, count-1.
- Simultaneous push and pop: count is unchanged, the FIFO pointers both advance, and ordering is preserved.
- rvalid with count == 0: no host rvalid asserted, proto_err_o set to 1 and held until reset, count stays 0 (no underflow).
- Pointers wrap modulo MAX_OUTST. The FIFO is built from registers, not RAM.
- Reset mid-transaction:
  - All outstanding ownership is discarded.
  - A dev_rvalid_i arriving after reset is treated as a protocol error.
  - The system resets the device together with the arbiter.
- Latency: zero added cycles on the request, grant and response paths. All paths are combinational through the registered state.

Decomposition:
- Shared include (Lucid64.vh): OBI host-ID constants OBI_HOST_FETCH=1'b0 and OBI_HOST_DATA=1'b1.
- Sub-module obi_owner_fifo (width 1, depth MAX_OUTST): push/pop/head/count/full/empty. Count is the source of outst_cnt_o.
- Arbitration, lock and muxing stay in the top module.

Test Plan:
- Single host, device gnt immediate: h1 issues a read to 0x1000, gnt same cycle, rvalid 2 cycles later with rdata 0xDEAD_BEEF -> h1_rvalid_o=1 with 0xDEAD_BEEF, h0_rvalid_o stays 0, count goes 0->1->0.
- Contention from reset: h0 and h1 both request, device grants every cycle -> grant order is h0, h1, h0, h1. Responses returned in order route h0, h1, h0, h1.
- Lock hold: h0 requests 0x2000, dev_gnt_i=0 for 3 cycles while h1 also requests -> dev_addr_o=0x2000 is stable all 4 cycles, h1 gets no grant, h1 is granted on the cycle after h0's handshake.
- Full (MAX_OUTST=2): two grants with no responses -> dev_req_o=0 despite pending requests. rvalid in cycle N -> dev_req_o=0 in cycle N, reasserts in N+1, and count never exceeds 2.
- Simultaneous push and pop at count=1 -> count stays 1, and the next rvalid routes to the newer owner.
- Spurious rvalid at count 0 -> both host rvalids 0, proto_err_o=1, held until rst_ni is pulsed asynchronously mid-cycle, which clears everything.
